// File: rtl/sum_gen_pkg.sv
// Shared constants and helpers for the mantissa sum generator and its prefix network.
// Used by sum_gen_pipe and, when SUM_GEN_LZC_EN is defined, by lzc32.
package sum_gen_pkg;

  localparam logic [7:0] KGP_K  = 8'h6B;
  localparam logic [7:0] KGP_P  = 8'h70;
  localparam logic [7:0] KGP_G  = 8'h67;
  localparam int         MANT_W = 32;
  localparam int         LZC_W  = 6;

  // A resolved prefix character may only be kill or generate; propagate means unresolved.
  function automatic logic kgp_is_resolved(input logic [7:0] ch);
    logic ok;
    case (ch)
      KGP_K:   ok = 1'b1;
      KGP_G:   ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sum_gen_pipe_lzc32.sv
// Combinational 32-bit leading-zero counter; an all-zero input yields 32.
// Instantiated by sum_gen_pipe only when SUM_GEN_LZC_EN is defined.
module lzc32
  import sum_gen_pkg::*;
(
  input  logic [31:0]      value,
  output logic [LZC_W-1:0] count
);

  // Scan upward so the most significant set bit is the last one to write the count.
  always_comb begin
    count = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (value[i]) begin
        count = 6'd31 - 6'(i);
      end else begin
        count = count;
      end
    end
  end

endmodule

// File: rtl/sum_gen_pipe.sv
// Two-stage pipelined sum generator sitting behind the parallel-prefix carry network.
// Define SUM_GEN_LZC_EN to produce the leading-zero count; otherwise lzc is tied to 0.
module sum_gen_pipe
  import sum_gen_pkg::*;
#(
  parameter int W = MANT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         a,
  input  logic [W-1:0]         b,
  input  logic                 cin,
  input  logic [W-1:0][7:0]    kgp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         sum,
  output logic                 cout,
  output logic                 ovf,
  output logic                 zero,
  output logic                 bad_code,
  output logic [LZC_W-1:0]     lzc
);

  logic              s1_valid_r;
  logic [W-1:0]      a_r;
  logic [W-1:0]      b_r;
  logic              cin_r;
  logic [W-1:0][7:0] kgp_r;

  logic              out_load_s;
  logic              s1_load_s;
  logic              accept_s;

  logic [W-1:0]      carry_s;
  logic [W-1:0]      sum_s;
  logic              cout_s;
  logic              ovf_s;
  logic              zero_s;
  logic              bad_s;
  logic [LZC_W-1:0]  lzc_s;

  assign out_load_s = !out_valid || out_ready;
  assign s1_load_s  = !s1_valid_r || out_load_s;
  assign in_ready   = !rst && !(s1_valid_r && out_valid && !out_ready);
  assign accept_s   = in_valid && in_ready;

  // Stage 1: capture operands and the prefix vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      a_r        <= {W{1'b0}};
      b_r        <= {W{1'b0}};
      cin_r      <= 1'b0;
      kgp_r      <= {(W*8){1'b0}};
    end else if (s1_load_s) begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        a_r   <= a;
        b_r   <= b;
        cin_r <= cin;
        kgp_r <= kgp;
      end
    end
  end

  // Carries come straight from the resolved prefix characters of the bit below.
  always_comb begin
    carry_s    = {W{1'b0}};
    bad_s      = 1'b0;
    carry_s[0] = cin_r;
    for (int i = 1; i < W; i++) begin
      carry_s[i] = (kgp_r[i-1] == KGP_G);
    end
    for (int i = 0; i < W; i++) begin
      bad_s = bad_s | !kgp_is_resolved(kgp_r[i]);
    end
    sum_s  = a_r ^ b_r ^ carry_s;
    cout_s = (kgp_r[W-1] == KGP_G);
    ovf_s  = carry_s[W-1] ^ cout_s;
    zero_s = ~|sum_s;
  end

`ifdef SUM_GEN_LZC_EN
  lzc32 u_lzc (
    .value (sum_s),
    .count (lzc_s)
  );
`else
  assign lzc_s = {LZC_W{1'b0}};
`endif

  // Output stage: results are held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= {W{1'b0}};
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      bad_code  <= 1'b0;
      lzc       <= {LZC_W{1'b0}};
    end else if (out_load_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        sum      <= sum_s;
        cout     <= cout_s;
        ovf      <= ovf_s;
        zero     <= zero_s;
        bad_code <= bad_s;
        lzc      <= lzc_s;
      end
    end
  end

endmodule

// File: tb/tb_sum_gen_pipe.sv
// Directed self-checking bench for sum_gen_pipe; expected lzc follows SUM_GEN_LZC_EN.
module tb_sum_gen_pipe;
  import sum_gen_pkg::*;

  typedef logic [31:0][7:0] kgp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  kgp_t        kgp;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic        bad_code;
  logic [5:0]  lzc;

  int compared   = 0;
  int mismatched = 0;

  sum_gen_pipe #(.W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .kgp(kgp),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero),
    .bad_code(bad_code), .lzc(lzc)
  );

  always #5 clk = ~clk;

  function automatic kgp_t fill(input logic [7:0] ch);
    kgp_t v;
    for (int i = 0; i < 32; i++) v[i] = ch;
    return v;
  endfunction

  function automatic logic [31:0] exp_lzc(input logic [31:0] n);
`ifdef SUM_GEN_LZC_EN
    return n;
`else
    return 32'd0 & n;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e_sum, input logic e_cout,
                         input logic e_ovf, input logic e_zero, input logic e_bad,
                         input logic [31:0] e_lzc);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".sum"},       sum,                e_sum);
    chk({tag, ".cout"},      {31'd0, cout},      {31'd0, e_cout});
    chk({tag, ".ovf"},       {31'd0, ovf},       {31'd0, e_ovf});
    chk({tag, ".zero"},      {31'd0, zero},      {31'd0, e_zero});
    chk({tag, ".bad_code"},  {31'd0, bad_code},  {31'd0, e_bad});
    chk({tag, ".lzc"},       {26'd0, lzc},       exp_lzc(e_lzc));
  endtask

  task automatic drive(input logic [31:0] va, input logic [31:0] vb, input logic vc, input kgp_t vk);
    in_valid = 1'b1;
    a = va;
    b = vb;
    cin = vc;
    kgp = vk;
  endtask

  initial begin
    kgp_t k;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = 32'd0; b = 32'd0; cin = 1'b0; kgp = fill(KGP_K);
    tick(); tick();
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.sum",       sum,                32'd0);
    chk("rst.flags",     {27'd0, cout, ovf, zero, bad_code, 1'b0}, 32'd0);
    chk("rst.lzc",       {26'd0, lzc},       32'd0);
    chk("rst.in_ready",  {31'd0, in_ready},  32'd0);
    rst = 1'b0;
    #1;
    chk("rel.in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back stream with a free-running consumer.
    drive(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, fill(KGP_G));
    tick();
    chk("t1.lat1.out_valid", {31'd0, out_valid}, 32'd0);
    k = fill(KGP_G); k[31] = KGP_K;
    drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, k);
    tick();
    chk_out("t1", 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 32'd32);
    drive(32'h0000_0100, 32'h0000_0000, 1'b0, fill(KGP_K));
    tick();
    chk_out("t2", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    k = fill(KGP_K); k[5] = KGP_P;
    drive(32'h0000_0000, 32'h0000_0000, 1'b1, k);
    tick();
    chk_out("t3", 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0, 32'd23);
    drive(32'h0000_0000, 32'h0000_0000, 1'b0, fill(KGP_K));
    tick();
    chk_out("t4bad", 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1, 32'd31);
    in_valid = 1'b0;
    tick();
    chk_out("t5", 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'd32);
    tick();
    chk("drain.out_valid", {31'd0, out_valid}, 32'd0);

    // Stall: three back-to-back offers while the consumer is blocked.
    out_ready = 1'b0;
    drive(32'd10, 32'd0, 1'b0, fill(KGP_K));
    tick();
    drive(32'd20, 32'd0, 1'b0, fill(KGP_K));
    tick();
    drive(32'd30, 32'd0, 1'b0, fill(KGP_K));
    chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("stall.sum", sum, 32'd10);
      chk("stall.out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall.in_ready_hold", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("shift.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk_out("stall.y", 32'd20, 1'b0, 1'b0, 1'b0, 1'b0, 32'd27);
    tick();
    chk_out("stall.z", 32'd30, 1'b0, 1'b0, 1'b0, 1'b0, 32'd27);
    tick();
    chk("stall.nodup", {31'd0, out_valid}, 32'd0);

    // Reset with both stages occupied.
    out_ready = 1'b0;
    drive(32'h11, 32'd0, 1'b0, fill(KGP_K));
    tick();
    drive(32'h22, 32'd0, 1'b0, fill(KGP_K));
    tick();
    chk("full.in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1; in_valid = 1'b0;
    tick();
    chk("mrst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst.sum", sum, 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    tick();
    chk("mrst.stale", {31'd0, out_valid}, 32'd0);
    drive(32'h33, 32'd0, 1'b0, fill(KGP_K));
    tick();
    in_valid = 1'b0;
    chk("mrst.lat1", {31'd0, out_valid}, 32'd0);
    tick();
    chk_out("mrst.first", 32'h33, 1'b0, 1'b0, 1'b0, 1'b0, 32'd26);
    tick();
    chk("mrst.end", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
